// File: rtl/sobel_capture_ctrl_pkg.sv
// Shared types and helpers for the Sobel edge-frame capture controller.
package sobel_capture_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DONE
  } cap_state_e;

  localparam int unsigned H_ACT_DEF    = 640;
  localparam int unsigned V_ACT_DEF    = 480;
  localparam int unsigned ADDR_W_DEF   = 16;
  localparam int unsigned PIX_PER_BYTE = 8;

  function automatic int unsigned frame_bytes(input int unsigned h_act, input int unsigned v_act);
    return (h_act * v_act) / PIX_PER_BYTE;
  endfunction

  // Pixels pack LSB first: pixel n lands in bit n[2:0] of its byte.
  function automatic logic [7:0] set_bit(input logic [7:0] b, input logic [2:0] idx, input logic v);
    logic [7:0] r;
    r      = b;
    r[idx] = v;
    return r;
  endfunction

endpackage

// File: rtl/sobel_capture_ctrl_rr_arb2.sv
// Two-way round-robin read arbiter; a pending capture write blocks all grants.
module sobel_capture_ctrl_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       block,
  output logic [1:0] gnt
);

  // 1 = requester 1 was granted last; reset value favours requester 0.
  logic last_q, last_d;

  always_comb begin
    gnt = '0;
    if (!block) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_q ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
    end
    last_d = last_q;
    if (gnt[1]) begin
      last_d = 1'b1;
    end else if (gnt[0]) begin
      last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/sobel_capture_ctrl.sv
// Captures one frame of Sobel edge bits into a byte-wide BRAM and arbitrates reads.
// Define SOBEL_CAP_CONTINUOUS_EN to re-arm automatically after every stored frame.
module sobel_capture_ctrl
  import sobel_capture_ctrl_pkg::*;
#(
  parameter int unsigned H_ACT  = H_ACT_DEF,
  parameter int unsigned V_ACT  = V_ACT_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  logic              pix_edge,
  output logic              busy,
  output logic              done,
  output logic              err_short,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [7:0]        bram_wdata,
  input  logic [7:0]        bram_rdata,
  input  logic [1:0]        rd_req,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [1:0]        rd_gnt,
  output logic [1:0]        rd_valid,
  output logic [7:0]        rd_data
);

  localparam int unsigned FRAME_PIX = H_ACT * V_ACT;
  localparam int unsigned CNT_W     = $clog2(FRAME_PIX + 1);
  localparam logic [CNT_W-1:0]  FRAME_PIX_C = CNT_W'(FRAME_PIX);
  localparam logic [ADDR_W-1:0] LAST_BYTE_C = ADDR_W'(frame_bytes(H_ACT, V_ACT) - 1);

  cap_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        pack_q, pack_d;
  logic              wb_vld_q, wb_vld_d;
  logic              wb_last_q, wb_last_d;
  logic [7:0]        wb_data_q, wb_data_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        rd_valid_q, rd_valid_d;

  logic              accept, restart;
  logic [CNT_W-1:0]  pix_n;
  logic [7:0]        byte_n;
  logic [1:0]        gnt;

  sobel_capture_ctrl_rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst   (rst),
    .req   (rd_req),
    .block (wb_vld_q),
    .gnt   (gnt)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pack_d    = pack_q;
    wb_vld_d  = 1'b0;
    wb_last_d = 1'b0;
    wb_data_d = wb_data_q;
    wb_addr_d = wb_addr_q;
    err_d     = err_q;
    accept    = 1'b0;
    restart   = 1'b0;
    pix_n     = '0;
    byte_n    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d = ST_ARMED;
          err_d   = 1'b0;
        end
      end
      ST_ARMED: begin
        if (frame_start && pix_valid) begin
          state_d = ST_CAPTURE;
          accept  = 1'b1;
          restart = 1'b1;
        end
      end
      ST_CAPTURE: begin
        // Leave once the final byte's write is on the port; later pixels are ignored.
        if (wb_vld_q && wb_last_q) begin
          state_d = ST_DONE;
        end else if (pix_valid && (cnt_q < FRAME_PIX_C)) begin
          accept = 1'b1;
          if (frame_start) begin
            restart = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      ST_DONE: begin
`ifdef SOBEL_CAP_CONTINUOUS_EN
        state_d = ST_ARMED;
        if (arm) begin
          err_d = 1'b0;
        end
`else
        if (arm) begin
          state_d = ST_ARMED;
          err_d   = 1'b0;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      pix_n  = restart ? '0 : cnt_q;
      byte_n = set_bit(restart ? 8'h00 : pack_q, pix_n[2:0], pix_edge);
      cnt_d  = pix_n + CNT_W'(1);
      if (&pix_n[2:0]) begin
        wb_vld_d  = 1'b1;
        wb_data_d = byte_n;
        wb_addr_d = ADDR_W'(pix_n >> 3);
        wb_last_d = (ADDR_W'(pix_n >> 3) == LAST_BYTE_C);
        pack_d    = '0;
      end else begin
        pack_d = byte_n;
      end
    end

    busy_d     = (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
    done_d     = (state_d == ST_DONE);
    rd_valid_d = gnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pack_q     <= '0;
      wb_vld_q   <= 1'b0;
      wb_last_q  <= 1'b0;
      wb_data_q  <= '0;
      wb_addr_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pack_q     <= pack_d;
      wb_vld_q   <= wb_vld_d;
      wb_last_q  <= wb_last_d;
      wb_data_q  <= wb_data_d;
      wb_addr_q  <= wb_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err_short  = err_q;
  assign rd_gnt     = gnt;
  assign rd_valid   = rd_valid_q;
  // BRAM output is already registered inside the RAM; gate it so rd_data is 0 when idle.
  assign rd_data    = (|rd_valid_q) ? bram_rdata : '0;

  assign bram_en    = wb_vld_q | (|gnt);
  assign bram_we    = wb_vld_q;
  assign bram_wdata = wb_vld_q ? wb_data_q : '0;
  assign bram_addr  = wb_vld_q ? wb_addr_q :
                      gnt[1]   ? rd_addr1  :
                      gnt[0]   ? rd_addr0  : '0;

endmodule

// File: tb/tb_sobel_capture_ctrl.sv
// Self-checking bench for sobel_capture_ctrl on a reduced 16x4 frame (8 bytes).
module tb_sobel_capture_ctrl;

  localparam int H  = 16;
  localparam int V  = 4;
  localparam int AW = 16;
  localparam int FP = H * V;
`ifdef SOBEL_CAP_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, arm, frame_start, pix_valid, pix_edge;
  logic          busy, done, err_short, bram_en, bram_we;
  logic [AW-1:0] bram_addr, rd_addr0, rd_addr1;
  logic [7:0]    bram_wdata, rd_data;
  bit   [7:0]    bram_rdata;
  logic [1:0]    rd_req, rd_gnt, rd_valid;

  always #5 clk = ~clk;

  sobel_capture_ctrl #(.H_ACT(H), .V_ACT(V), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .arm(arm), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_edge(pix_edge), .busy(busy), .done(done), .err_short(err_short),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .bram_rdata(bram_rdata), .rd_req(rd_req), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data)
  );

  bit [7:0] mem [256];
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr[7:0]] <= bram_wdata;
      else         bram_rdata <= mem[bram_addr[7:0]];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: 0 idle, 1 armed, 2 capturing, 3 done.
  typedef struct packed { logic [AW-1:0] a; logic [7:0] d; } wr_t;
  wr_t      exp_q[$];
  int       m_state, m_cnt;
  bit       m_short;
  bit [7:0] m_acc;

  function automatic void model_reset();
    m_state = 0; m_cnt = 0; m_short = 0; m_acc = '0;
    exp_q.delete();
  endfunction

  function automatic void model_pixel(input bit fs, input bit e);
    if (m_state == 1) begin
      if (!fs) return;
      m_state = 2; m_cnt = 0; m_acc = '0;
    end else if (m_state == 2) begin
      if (m_cnt >= FP) return;
      if (fs) begin m_short = 1; m_cnt = 0; m_acc = '0; end
    end else begin
      return;
    end
    m_acc[m_cnt % 8] = e;
    if (m_cnt % 8 == 7) begin
      exp_q.push_back('{a: AW'(m_cnt / 8), d: m_acc});
      m_acc = '0;
    end
    m_cnt++;
    if (m_cnt == FP) m_state = CONT ? 1 : 3;
  endfunction

  function automatic bit edge_of(input int kind, input int n);
    logic [31:0] nn;
    nn = n;
    case (kind)
      0:       return nn[0];
      1:       return (n != FP - 1);
      2:       return (n % 3 == 0);
      default: return nn[1] ^ nn[3];
    endcase
  endfunction

  // Per-cycle compare against the model and the arbitration rules.
  logic [1:0] pv_gnt   = '0;
  logic [1:0] last_gnt = 2'b10;
  logic [7:0] pv_data  = '0;
  int         done_cycles = 0;

  always @(negedge clk) begin
    if (rst) begin
      pv_gnt   = '0;
      last_gnt = 2'b10;
    end else begin
      logic [1:0] eg;
      if (done) done_cycles++;
      chk("bram_en", bram_en, bram_we | (|rd_gnt));
      if (bram_we) begin
        chk("write_queued", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          wr_t w;
          w = exp_q.pop_front();
          chk("wr_addr", bram_addr, w.a);
          chk("wr_data", bram_wdata, w.d);
        end
        eg = 2'b00;
      end else begin
        case (rd_req)
          2'b01:   eg = 2'b01;
          2'b10:   eg = 2'b10;
          2'b11:   eg = (last_gnt == 2'b01) ? 2'b10 : 2'b01;
          default: eg = 2'b00;
        endcase
      end
      chk("rd_gnt", rd_gnt, eg);
      if (rd_gnt != 0) chk("rd_addr", bram_addr, rd_gnt[1] ? rd_addr1 : rd_addr0);
      chk("rd_valid", rd_valid, pv_gnt);
      if (rd_valid != 0) chk("rd_data", rd_data, pv_data);
      pv_gnt  = rd_gnt;
      pv_data = mem[bram_addr[7:0]];
      if (rd_gnt != 0) last_gnt = rd_gnt;
    end
  end

  task automatic end_cycle();
    @(posedge clk); #1;
    frame_start = 0; pix_valid = 0; pix_edge = 0;
  endtask

  task automatic drive_pix(input bit fs, input bit e);
    frame_start = fs; pix_valid = 1; pix_edge = e;
    model_pixel(fs, e);
  endtask

  task automatic send_frame(input int kind, input int npix);
    for (int n = 0; n < npix; n++) begin
      drive_pix(n == 0, edge_of(kind, n));
      end_cycle();
    end
  endtask

  task automatic do_arm();
    arm = 1;
    if (m_state == 0 || m_state == 3) begin m_state = 1; m_short = 0; end
    end_cycle();
    arm = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) end_cycle();
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    chk("done_seen", seen, 1);
    if (seen) begin
      chk("busy_at_done", busy, 0);
      chk("err_at_done", err_short, m_short);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_read(input int idx, input logic [AW-1:0] addr, input logic [7:0] exp);
    bit         got = 0;
    logic [1:0] want;
    want = (idx != 0) ? 2'b10 : 2'b01;
    if (idx != 0) rd_addr1 = addr; else rd_addr0 = addr;
    rd_req = want;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rd_gnt == want) begin got = 1; break; end
      @(posedge clk); #1;
    end
    chk("rd_grant_seen", got, 1);
    @(posedge clk); #1;
    rd_req = 0;
    if (got) begin
      @(negedge clk);
      chk("rd_literal", rd_data, exp);
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_short, 0);
    chk("rst_en", bram_en, 0);
    chk("rst_we", bram_we, 0);
    chk("rst_addr", bram_addr, 0);
    chk("rst_wdata", bram_wdata, 0);
    chk("rst_gnt", rd_gnt, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_rdata", rd_data, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 0; arm = 0; frame_start = 0; pix_valid = 0; pix_edge = 0;
    rd_req = 0; rd_addr0 = 0; rd_addr1 = 0;
    model_reset();
    #1 rst = 1;
    #2 check_reset_outputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;

    // All ones except the very last pixel: last byte 0x7F.
    do_arm();
    chk("busy_armed", busy, 1);
    send_frame(1, FP);
    wait_done();
    chk("queue_empty_1", exp_q.size(), 0);
    idle(3);
    chk("done_held", done, m_state == 3);
    chk("busy_after", busy, m_state == 1);
    do_read(0, 7, 8'h7F);
    do_read(1, 0, 8'hFF);

    // Reset (BRAM untouched), then both requesters held in IDLE alternate.
    rst = 1;
    end_cycle();
    rst = 0;
    model_reset();
    rd_addr0 = 7; rd_addr1 = 2; rd_req = 2'b11;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("alt_gnt", rd_gnt, (i % 2) ? 2'd2 : 2'd1);
      if (i > 0) chk("alt_data", rd_data, (i % 2) ? 8'h7F : 8'hFF);
      @(posedge clk); #1;
    end
    rd_req = 0;
    @(negedge clk);
    chk("alt_data_last", rd_data, 8'hFF);
    @(posedge clk); #1;

    // Pattern n[0] gives 0xAA; a read request lands on the first write cycle.
    do_arm();
    rd_addr0 = 3;
    for (int n = 0; n < FP; n++) begin
      drive_pix(n == 0, edge_of(0, n));
      if (n == 8) begin
        rd_req = 2'b01;
        @(negedge clk);
        chk("wr_cycle_we", bram_we, 1);
        chk("wr_cycle_gnt", rd_gnt, 0);
      end
      if (n == 9) begin
        @(negedge clk);
        chk("delayed_gnt", rd_gnt, 2'b01);
      end
      end_cycle();
      if (n == 9) rd_req = 0;
    end
    pix_valid = 1; pix_edge = 1;
    wait_done();
    pix_valid = 0; pix_edge = 0;
    chk("queue_empty_2", exp_q.size(), 0);
    do_read(0, 5, 8'hAA);
    do_read(1, 7, 8'hAA);

    // Short frame: restart at pixel 0 on the early frame_start.
    do_arm();
    chk("done_after_arm", done, m_state == 3);
    chk("err_after_arm", err_short, m_short);
    send_frame(2, 20);
    send_frame(3, FP);
    wait_done();
    chk("err_short_set", err_short, 1);
    chk("queue_empty_3", exp_q.size(), 0);
    do_read(0, 0, 8'hCC);
    do_read(1, 1, 8'h33);

    // Reset mid-capture, then a clean capture.
    do_arm();
    chk("err_cleared", err_short, m_short);
    send_frame(0, 30);
    #1 rst = 1;
    #1 check_reset_outputs();
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    do_arm();
    send_frame(3, FP);
    wait_done();
    chk("err_clean", err_short, 0);
    chk("queue_empty_4", exp_q.size(), 0);
    do_read(1, 1, 8'h33);
    do_read(0, 6, 8'hCC);

`ifdef SOBEL_CAP_CONTINUOUS_EN
    done_cycles = 0;
    send_frame(0, FP);
    wait_done();
    send_frame(1, FP);
    wait_done();
    idle(3);
    chk("done_pulses", done_cycles, 2);
    chk("queue_empty_5", exp_q.size(), 0);
`else
    do_arm();
    chk("rearm_busy", busy, 1);
    chk("rearm_done", done, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
